// File: rtl/fetch_unit.sv
// Instruction fetch front end.
// Owns the PC, issues single-outstanding reads on the instruction bus, and
// buffers returned words in a 2-entry in-order queue whose head drives the
// fetch pipeline register. Redirects flush the queue. A response that was
// already in flight when the redirect arrived is discarded (DROP state).
// A misaligned target produces one exception entry instead of a bus read,
// and fetch then halts until the next redirect.
module fetch_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ireq_valid,
    output logic [XLEN-1:0] ireq_addr,
    input  logic            iresp_data_ok,
    input  logic [31:0]     iresp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            out_exc
);

    // IDLE: no request. REQ: live request at req_pc. DROP: the request on the
    // bus belongs to a flushed path; its response is swallowed.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DROP
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            exc;
    } entry_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    function automatic logic is_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

    // Control state
    state_t          state_q,  state_d;
    logic [XLEN-1:0] pc_q,     pc_d;      // next PC to launch from
    logic [XLEN-1:0] req_pc_q, req_pc_d;  // address currently on the bus
    logic            halted_q, halted_d;  // misaligned fetch reported, wait for redirect

    // Queue state
    logic [1:0]      cnt_q,    cnt_d;
    logic            head_q,   head_d;
    entry_t          entry_q [2];
    entry_t          entry_d [2];

    // Internal handshakes between FSM and queue
    logic            pop;
    logic [1:0]      cnt_after_pop;
    logic            room;
    logic            push;
    entry_t          push_entry;
    logic            flush;
    logic [XLEN-1:0] resume_pc;
    logic            wr_idx;
    entry_t          head_entry;

    // Consumer side: the head leaves whenever it is valid and not stalled.
    // Launch is allowed only if the queue will have a free slot after this
    // cycle's pop, so a response can always be accepted without back-pressure.
    always_comb begin
        pop           = (cnt_q != 2'd0) && !stall;
        cnt_after_pop = cnt_q - {1'b0, pop};
        room          = (cnt_after_pop < 2'd2);
    end

    // Next-state logic for the fetch FSM, PC tracking and queue push requests.
    // NOTE: every signal written here gets a default first so no path through
    // the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        halted_d   = halted_q;
        flush      = 1'b0;
        push       = 1'b0;
        push_entry = '0;
        // In DROP the latest redirect wins; otherwise resume from the stored PC.
        resume_pc  = redirect_valid ? redirect_pc : pc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (redirect_valid) begin
                    flush    = 1'b1;
                    pc_d     = redirect_pc;
                    req_pc_d = redirect_pc;
                    halted_d = 1'b0;
                    // A misaligned target stays in IDLE and reports next cycle.
                    state_d  = is_aligned(redirect_pc[1:0]) ? ST_REQ : ST_IDLE;
                end else if (room && !halted_q) begin
                    if (!is_aligned(pc_q[1:0])) begin
                        push       = 1'b1;
                        push_entry = '{pc: pc_q, instr: 32'd0, exc: 1'b1};
                        halted_d   = 1'b1;
                    end else begin
                        req_pc_d = pc_q;
                        state_d  = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                if (redirect_valid) begin
                    flush    = 1'b1;
                    pc_d     = redirect_pc;
                    halted_d = 1'b0;
                    if (iresp_data_ok) begin
                        // Response and redirect together: the response is simply
                        // not pushed and the bus is free for the new target.
                        req_pc_d = redirect_pc;
                        state_d  = is_aligned(redirect_pc[1:0]) ? ST_REQ : ST_IDLE;
                    end else begin
                        // The bus has no abort, so keep the address and wait it out.
                        state_d = ST_DROP;
                    end
                end else if (iresp_data_ok) begin
                    push       = 1'b1;
                    push_entry = '{pc: req_pc_q, instr: iresp_data, exc: 1'b0};
                    pc_d       = req_pc_q + PC_STEP;
                    // Back-to-back only if the queue still has room after this push.
                    if (cnt_after_pop == 2'd0) begin
                        req_pc_d = req_pc_q + PC_STEP;
                        state_d  = ST_REQ;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end

            ST_DROP: begin
                if (redirect_valid) begin
                    flush    = 1'b1;
                    pc_d     = redirect_pc;
                    halted_d = 1'b0;
                end
                if (iresp_data_ok) begin
                    req_pc_d = resume_pc;
                    state_d  = is_aligned(resume_pc[1:0]) ? ST_REQ : ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Queue bookkeeping: write at the tail, advance the head on pop, and clear
    // the count on flush. Push and flush never coincide.
    always_comb begin
        entry_d[0] = entry_q[0];
        entry_d[1] = entry_q[1];
        // Tail slot; with two entries and a simultaneous pop this is the slot
        // being vacated, which is exactly where the new entry belongs.
        wr_idx     = head_q ^ cnt_q[0];
        if (push) begin
            entry_d[wr_idx] = push_entry;
        end
        if (flush) begin
            cnt_d  = 2'd0;
            head_d = 1'b0;
        end else begin
            cnt_d  = cnt_after_pop + {1'b0, push};
            head_d = head_q ^ pop;
        end
    end

    // Control and queue-pointer registers with synchronous reset.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            halted_q <= 1'b0;
            cnt_q    <= 2'd0;
            head_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
        end
    end

    // Queue payload storage.
    // NOTE: payload is not reset; cnt_q alone says which slots are live and the
    // outputs are gated by it, so stale contents are never visible.
    always_ff @(posedge clk) begin
        entry_q[0] <= entry_d[0];
        entry_q[1] <= entry_d[1];
    end

    // Bus request straight from state; outputs straight from queue storage.
    assign ireq_valid = (state_q != ST_IDLE);
    assign ireq_addr  = req_pc_q;

    assign head_entry = entry_q[head_q];
    assign out_valid  = (cnt_q != 2'd0);
    assign out_pc     = out_valid ? head_entry.pc    : '0;
    assign out_instr  = out_valid ? head_entry.instr : 32'd0;
    assign out_exc    = out_valid ? head_entry.exc   : 1'b0;

    // A push into a full queue without a pop cannot happen by construction.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && cnt_q == 2'd2));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// A bus responder answers each request after a programmable number of wait
// cycles with data = address[31:0]. Expected head entries are queued when the
// stimulus that produces them is applied and compared on every pop.
module tb_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc;
    } entry_t;

    typedef struct {
        logic [63:0] pc;
        int          lat;
        int          n;
        logic        exc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc;

    int          lat;
    int          wait_cnt = 0;
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          pop_cnt  = 0;
    logic        hold_pending = 1'b0;
    logic [63:0] hold_addr    = '0;
    entry_t      exp_q [$];
    vec_t        vecs [6];

    fetch_unit #(.XLEN(64), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_exc        (out_exc)
    );

    always #5 clk = ~clk;

    // Responder: data_ok once the request has waited lat cycles (0 = same cycle).
    assign iresp_data_ok = ireq_valid && (wait_cnt >= lat);
    assign iresp_data    = ireq_addr[31:0];

    always @(posedge clk) begin
        if (reset || !ireq_valid || iresp_data_ok) wait_cnt <= 0;
        else                                       wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] pc, input logic exc);
        entry_t e;
        e.pc    = pc;
        e.instr = exc ? 32'd0 : pc[31:0];
        e.exc   = exc;
        exp_q.push_back(e);
    endtask

    // One clock cycle: sample at mid-cycle (inputs already driven), then advance
    // to the next falling edge where the caller drives the following inputs.
    task automatic tick();
        entry_t e;
        #1;
        if (!reset && out_valid === 1'b1 && !stall) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pop: got pc %h, expected no entry", out_pc);
            end else begin
                e = exp_q.pop_front();
                check("pop_pc",    out_pc,            e.pc);
                check("pop_instr", 64'(out_instr),    64'(e.instr));
                check("pop_exc",   64'(out_exc),      64'(e.exc));
            end
        end
        if (hold_pending && !reset) begin
            check("hold_valid", 64'(ireq_valid), 64'd1);
            check("hold_addr",  ireq_addr,       hold_addr);
        end
        hold_pending = !reset && (ireq_valid === 1'b1) && !iresp_data_ok;
        hold_addr    = ireq_addr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_redirect(input logic [63:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    // Queue n sequential expected entries from base, release stall until exactly
    // n pops have happened, then stall again.
    task automatic drain(input logic [63:0] base, input int n, input logic exc);
        int start;
        int budget;
        for (int i = 0; i < n; i++) push_exp(base + 64'(4 * i), exc);
        start  = pop_cnt;
        budget = 0;
        while ((pop_cnt - start) < n && budget < 200) begin
            stall = 1'b0;
            tick();
            budget++;
        end
        stall = 1'b1;
        if ((pop_cnt - start) < n) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pops, expected %0d", pop_cnt - start, n);
            exp_q.delete();
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Let the queue fill and the FSM go quiet with the consumer stalled.
    task automatic settle();
        stall = 1'b1;
        repeat (12) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        vecs[0] = '{pc: 64'h8000_4000,           lat: 0, n: 4, exc: 1'b0};
        vecs[1] = '{pc: 64'h8000_5000,           lat: 2, n: 3, exc: 1'b0};
        vecs[2] = '{pc: 64'hFFFF_FFFF_FFFF_FFF8, lat: 0, n: 4, exc: 1'b0};
        vecs[3] = '{pc: 64'h8000_6000,           lat: 1, n: 3, exc: 1'b0};
        vecs[4] = '{pc: 64'h8000_7001,           lat: 0, n: 1, exc: 1'b1};
        vecs[5] = '{pc: 64'h8000_3000,           lat: 0, n: 3, exc: 1'b0};

        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        lat            = 0;

        // Reset state
        repeat (3) tick();
        check("rst_ireq_valid", 64'(ireq_valid), 64'd0);
        check("rst_out_valid",  64'(out_valid),  64'd0);
        check("rst_out_pc",     out_pc,          64'd0);
        check("rst_out_instr",  64'(out_instr),  64'd0);
        check("rst_out_exc",    64'(out_exc),    64'd0);

        // 1: zero-wait streaming from RESET_PC
        for (int i = 0; i < 3; i++) push_exp(RESET_PC + 64'(4 * i), 1'b0);
        reset = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("t1_first_valid_latency", 64'(n), 64'd2);
        for (int i = 0; i < 3; i++) begin
            check("t1_valid", 64'(out_valid), 64'd1);
            check("t1_pc",    out_pc,         RESET_PC + 64'(4 * i));
            tick();
        end

        // 2: stall fills the queue and stops requests; release keeps order
        stall = 1'b1;
        repeat (6) tick();
        check("t2_ireq_off",   64'(ireq_valid), 64'd0);
        check("t2_out_valid",  64'(out_valid),  64'd1);
        check("t2_head_pc",    out_pc,          RESET_PC + 64'h0C);
        drain(RESET_PC + 64'h0C, 5, 1'b0);

        // Pop in the redirect cycle is still delivered
        repeat (3) tick();
        check("t3_head_before", out_pc, RESET_PC + 64'h20);
        push_exp(RESET_PC + 64'h20, 1'b0);
        lat   = 3;
        stall = 1'b0;
        do_redirect(64'h8000_0800);
        stall = 1'b1;
        check("t3_pop_on_redirect", 64'(exp_q.size()), 64'd0);

        // 3: redirect during a wait cycle; old address held until data_ok
        check("t3_req_addr", ireq_addr, 64'h8000_0800);
        tick();
        do_redirect(64'h8000_1000);
        check("t3_drop_valid", 64'(ireq_valid), 64'd1);
        check("t3_drop_addr",  ireq_addr,       64'h8000_0800);
        check("t3_drop_out",   64'(out_valid),  64'd0);
        tick();
        check("t3_drop_ok",    64'(iresp_data_ok), 64'd1);
        check("t3_drop_addr2", ireq_addr,          64'h8000_0800);
        tick();
        check("t3_new_addr",   ireq_addr,          64'h8000_1000);
        drain(64'h8000_1000, 2, 1'b0);
        settle();

        // 4: redirect together with data_ok discards the response
        lat = 2;
        do_redirect(64'h8000_0900);
        tick();
        tick();
        check("t4_ok_now", 64'(iresp_data_ok), 64'd1);
        do_redirect(64'h8000_2000);
        check("t4_req_valid", 64'(ireq_valid), 64'd1);
        check("t4_req_addr",  ireq_addr,       64'h8000_2000);
        drain(64'h8000_2000, 2, 1'b0);
        settle();

        // 5: misaligned target -> one exception entry, no bus activity, halt
        lat = 0;
        do_redirect(64'h8000_1002);
        check("t5_no_req0",  64'(ireq_valid), 64'd0);
        tick();
        check("t5_valid",    64'(out_valid),  64'd1);
        check("t5_exc",      64'(out_exc),    64'd1);
        check("t5_pc",       out_pc,          64'h8000_1002);
        check("t5_instr",    64'(out_instr),  64'd0);
        check("t5_no_req1",  64'(ireq_valid), 64'd0);
        drain(64'h8000_1002, 1, 1'b1);
        stall = 1'b0;
        repeat (4) begin
            tick();
            check("t5_halt_req", 64'(ireq_valid), 64'd0);
            check("t5_halt_out", 64'(out_valid),  64'd0);
        end
        stall = 1'b1;
        do_redirect(64'h8000_3000);
        check("t5_resume_addr", ireq_addr, 64'h8000_3000);
        drain(64'h8000_3000, 3, 1'b0);
        settle();

        // Table of redirect targets, bus latencies and expected streams
        for (int v = 0; v < 6; v++) begin
            lat   = vecs[v].lat;
            stall = 1'b1;
            do_redirect(vecs[v].pc);
            drain(vecs[v].pc, vecs[v].n, vecs[v].exc);
            settle();
        end

        // 6: reset in the middle of a request with an entry queued
        lat = 3;
        do_redirect(64'h8000_0A00);
        repeat (5) tick();
        check("t6_pre_valid", 64'(out_valid),  64'd1);
        check("t6_pre_pc",    out_pc,          64'h8000_0A00);
        check("t6_pre_req",   64'(ireq_valid), 64'd1);
        check("t6_pre_addr",  ireq_addr,       64'h8000_0A04);
        reset = 1'b1;
        tick();
        check("t6_rst_valid", 64'(out_valid),  64'd0);
        check("t6_rst_req",   64'(ireq_valid), 64'd0);
        check("t6_rst_pc",    out_pc,          64'd0);
        reset = 1'b0;
        lat   = 0;
        tick();
        check("t6_restart_valid", 64'(ireq_valid), 64'd1);
        check("t6_restart_addr",  ireq_addr,       RESET_PC);
        drain(RESET_PC, 3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
